// File: rtl/param_access_ctrl.sv
// param_access_ctrl: command sequencer in front of the parameterised register/memory stage.
// It buffers read/write commands in a small FIFO and issues them one at a time as
// single-cycle strobes. On a read it waits for the stage's registered ready. Each command
// produces one response, and responses come back in command order.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   cmd_valid/cmd_ready        command stream handshake
//   cmd_write/addr/wdata       command type (1 = write), address, write payload
//   mem_write_en/read_en       downstream single-cycle strobes
//   mem_addr/mem_wdata         downstream address/data_in; they hold the last issued values
//   mem_rdata/mem_ready        downstream data_out and registered ready
//   rsp_valid/rsp_ready        response stream handshake
//   rsp_write/rdata/err        echoed type, read data (0 for writes), read timeout flag
//   busy                       FIFO non-empty or a command is in progress
//
// Optional feature: define PARAM_ACC_TIMEOUT_EN to abort a read that waits TIMEOUT_CYCLES
// cycles without mem_ready. The aborted read returns rsp_err=1 and rsp_rdata=0.
module param_access_ctrl #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned ADDR_WIDTH     = 4,
  parameter int unsigned WDATA_WIDTH    = 100,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   cmd_write,
  input  logic [ADDR_WIDTH-1:0]  cmd_addr,
  input  logic [WDATA_WIDTH-1:0] cmd_wdata,
  output logic                   mem_write_en,
  output logic                   mem_read_en,
  output logic [ADDR_WIDTH-1:0]  mem_addr,
  output logic [WDATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0]  mem_rdata,
  input  logic                   mem_ready,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_write,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   rsp_err,
  output logic                   busy
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned EntW = 1 + ADDR_WIDTH + WDATA_WIDTH;

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

  state_e state_q, state_d;

  // Command FIFO
  logic [EntW-1:0] fifo_mem [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, empty, push, pop;

  assign full      = (count_q == CntW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign cmd_ready = !full;
  assign push      = cmd_valid && cmd_ready;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Issue register. It also drives mem_addr/mem_wdata, so those hold the last issued command.
  logic                   issue_write_q;
  logic [ADDR_WIDTH-1:0]  issue_addr_q;
  logic [WDATA_WIDTH-1:0] issue_wdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_write_q <= 1'b0;
      issue_addr_q  <= '0;
      issue_wdata_q <= '0;
    end else if (pop) begin
      {issue_write_q, issue_addr_q, issue_wdata_q} <= fifo_mem[rd_ptr_q];
    end
  end

  // Read completion: either data came back or the optional timeout fired.
  logic rd_capture;
  logic timeout;

  assign rd_capture = (state_q == StWait) && mem_ready;

`ifdef PARAM_ACC_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TmoW-1:0] wait_cnt_q;
  logic            rsp_err_q;

  // wait_cnt_q counts the WAIT cycles already spent. The limit is therefore hit on the
  // TIMEOUT_CYCLES-th WAIT cycle, and mem_ready in that same cycle still wins.
  assign timeout = (state_q == StWait) && !mem_ready &&
                   (wait_cnt_q == TmoW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (state_q == StIssue) begin
        wait_cnt_q <= '0;
      end else if (state_q == StWait) begin
        wait_cnt_q <= wait_cnt_q + TmoW'(1);
      end
      if (state_q == StIssue || rd_capture) begin
        rsp_err_q <= 1'b0;
      end else if (timeout) begin
        rsp_err_q <= 1'b1;
      end
    end
  end

  assign rsp_err = rsp_err_q;
`else
  assign timeout = 1'b0;
  assign rsp_err = 1'b0;
`endif

  // FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      StIdle: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: state_d = issue_write_q ? StResp : StWait;
      StWait:  if (rd_capture || timeout) state_d = StResp;
      StResp:  if (rsp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Response payload
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else if (state_q == StIssue) begin
      rsp_write_q <= issue_write_q;
      if (issue_write_q) rsp_rdata_q <= '0;
    end else if (rd_capture) begin
      rsp_rdata_q <= mem_rdata;
    end else if (timeout) begin
      rsp_rdata_q <= '0;
    end
  end

  assign mem_write_en = (state_q == StIssue) && issue_write_q;
  assign mem_read_en  = (state_q == StIssue) && !issue_write_q;
  assign mem_addr     = issue_addr_q;
  assign mem_wdata    = issue_wdata_q;
  assign rsp_valid    = (state_q == StResp);
  assign rsp_write    = rsp_write_q;
  assign rsp_rdata    = rsp_rdata_q;
  assign busy         = !empty || (state_q != StIdle);

endmodule

// File: tb/tb_param_access_ctrl.sv
// Randomised bench for param_access_ctrl. It contains a downstream memory stub and a
// transaction-level reference model: a command queue, the one in-flight command and a
// shadow memory. The outputs are compared against that model on every falling edge.
// Inputs are driven 2 ns after each rising edge.
module tb_param_access_ctrl;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int WW = 100;
  localparam int FD = 4;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0, cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [WW-1:0] cmd_wdata = '0;
  logic          cmd_ready, mem_write_en, mem_read_en, rsp_valid, rsp_write, rsp_err, busy;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata, rsp_rdata;
  logic          mem_ready;
  logic          rsp_ready = 1'b0;

  always #5 clk = ~clk;

  param_access_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WDATA_WIDTH(WW), .FIFO_DEPTH(FD), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .mem_write_en(mem_write_en), .mem_read_en(mem_read_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  int checks = 0;
  int failures = 0;
  int n_rsp = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Downstream stub: registered ready, arriving lat_r cycles after the read strobe (min 1).
  logic [7:0] dmem [16] = '{default: 8'h00};
  int         lat_force = -1;
  int         lat_max = 0;
  int         lat_r = 0;
  logic       pend;
  int         dly;
  logic [3:0] raddr;

  function automatic int get_lat();
    if (lat_force >= 0) return lat_force;
    return int'($urandom_range(0, lat_max));
  endfunction

  always @(posedge clk) lat_r <= get_lat();

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_ready <= 1'b0;
      mem_rdata <= '0;
      pend      <= 1'b0;
      dly       <= 0;
      raddr     <= '0;
    end else begin
      mem_ready <= 1'b0;
      if (mem_write_en) dmem[mem_addr] <= mem_wdata[7:0];
      if (mem_read_en) begin
        if (lat_r == 0) begin
          mem_ready <= 1'b1;
          mem_rdata <= dmem[mem_addr];
          pend      <= 1'b0;
        end else begin
          pend  <= 1'b1;
          dly   <= lat_r;
          raddr <= mem_addr;
        end
      end else if (pend) begin
        if (dly == 1) begin
          mem_ready <= 1'b1;
          mem_rdata <= dmem[raddr];
          pend      <= 1'b0;
        end else begin
          dly <= dly - 1;
        end
      end
    end
  end

  // Reference model
  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [WW-1:0] d;
  } cmd_t;

  cmd_t          mq[$];
  cmd_t          cur;
  cmd_t          newc;
  int            ph = 0;  // 0 none, 1 strobe cycle, 2 awaiting read data, 3 response held
  int            wcnt = 0;
  bit            acc;
  logic [7:0]    ref_mem [16] = '{default: 8'h00};
  bit            exp_cmd_ready = 1'b1, exp_busy = 1'b0, exp_wen = 1'b0, exp_ren = 1'b0;
  bit            exp_rsp_valid = 1'b0, exp_rsp_write = 1'b0, exp_rsp_err = 1'b0;
  logic [AW-1:0] exp_addr = '0;
  logic [WW-1:0] exp_wdata = '0;
  logic [DW-1:0] exp_rsp_rdata = '0;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      ph        = 0;
      exp_addr  = '0;
      exp_wdata = '0;
    end else begin
      acc = cmd_valid && (mq.size() < FD);
      case (ph)
        0: if (mq.size() > 0) begin
          cur       = mq.pop_front();
          exp_addr  = cur.a;
          exp_wdata = cur.d;
          ph        = 1;
        end
        1: begin
          wcnt = 0;
          if (cur.w) begin
            ref_mem[cur.a] = cur.d[7:0];
            exp_rsp_write  = 1'b1;
            exp_rsp_rdata  = '0;
            exp_rsp_err    = 1'b0;
            ph             = 3;
          end else begin
            ph = 2;
          end
        end
        2: begin
          wcnt++;
          if (mem_ready) begin
            exp_rsp_write = 1'b0;
            exp_rsp_rdata = ref_mem[cur.a];
            exp_rsp_err   = 1'b0;
            ph            = 3;
          end
`ifdef PARAM_ACC_TIMEOUT_EN
          else if (wcnt == TO) begin
            exp_rsp_write = 1'b0;
            exp_rsp_rdata = '0;
            exp_rsp_err   = 1'b1;
            ph            = 3;
          end
`endif
        end
        default: if (rsp_ready) ph = 0;
      endcase
      if (acc) begin
        newc.w = cmd_write;
        newc.a = cmd_addr;
        newc.d = cmd_wdata;
        mq.push_back(newc);
      end
    end
    exp_cmd_ready = (mq.size() < FD);
    exp_busy      = (mq.size() > 0) || (ph != 0);
    exp_wen       = (ph == 1) && cur.w;
    exp_ren       = (ph == 1) && !cur.w;
    exp_rsp_valid = (ph == 3);
  end

  // Per-cycle compare
  initial forever begin
    @(negedge clk);
    chk("cmd_ready", cmd_ready, exp_cmd_ready);
    chk("busy", busy, exp_busy);
    chk("mem_write_en", mem_write_en, exp_wen);
    chk("mem_read_en", mem_read_en, exp_ren);
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wdata", mem_wdata, exp_wdata);
    chk("rsp_valid", rsp_valid, exp_rsp_valid);
    if (exp_rsp_valid) begin
      chk("rsp_write", rsp_write, exp_rsp_write);
      chk("rsp_rdata", rsp_rdata, exp_rsp_rdata);
      chk("rsp_err", rsp_err, exp_rsp_err);
    end
    if (rsp_valid && rsp_ready) n_rsp++;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [WW-1:0] rnd_wdata();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[WW-1:0];
  endfunction

  // Offers one command and returns in the cycle after it was accepted.
  task automatic send(input logic w, input logic [AW-1:0] a, input logic [WW-1:0] d);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_wdata = d;
    while (!cmd_ready && n < 200) begin
      step();
      n++;
    end
    chk("send_ready", cmd_ready, 1'b1);
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (busy && n < 400) begin
      step();
      n++;
    end
    chk(nm, busy, 1'b0);
  endtask

  initial begin
    int n0;
    int n;
    int bp_acc;
    repeat (3) step();
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    chk("rst_wen", mem_write_en, 1'b0);
    chk("rst_ren", mem_read_en, 1'b0);
    chk("rst_addr", mem_addr, 4'h0);
    chk("rst_wdata", mem_wdata, 100'h0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_write", rsp_write, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 8'h00);
    chk("rst_rsp_err", rsp_err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    step();

    // Minimum-latency write
    rsp_ready = 1'b1;
    send(1'b1, 4'h3, 100'h0AB);
    chk("wr_c1_rsp_valid", rsp_valid, 1'b0);
    step();
    chk("wr_c2_wen", mem_write_en, 1'b1);
    chk("wr_c2_addr", mem_addr, 4'h3);
    chk("wr_c2_wdata", mem_wdata, 100'h0AB);
    step();
    chk("wr_c3_rsp_valid", rsp_valid, 1'b1);
    chk("wr_c3_rsp_write", rsp_write, 1'b1);
    chk("wr_c3_rsp_rdata", rsp_rdata, 8'h00);
    step();
    chk("wr_c4_wen", mem_write_en, 1'b0);
    chk("wr_c4_rsp_valid", rsp_valid, 1'b0);

    // Minimum-latency read of 0xFF
    send(1'b1, 4'h5, 100'h0FF);
    repeat (4) step();
    send(1'b0, 4'h5, 100'h0);
    step();
    chk("rd_c2_ren", mem_read_en, 1'b1);
    chk("rd_c2_addr", mem_addr, 4'h5);
    step();
    chk("rd_c3_rsp_valid", rsp_valid, 1'b0);
    step();
    chk("rd_c4_rsp_valid", rsp_valid, 1'b1);
    chk("rd_c4_rdata", rsp_rdata, 8'hFF);
    chk("rd_c4_err", rsp_err, 1'b0);
    chk("rd_c4_write", rsp_write, 1'b0);
    step();

`ifdef PARAM_ACC_TIMEOUT_EN
    lat_force = 1000;
    repeat (2) step();
    send(1'b0, 4'h5, 100'h0);
    n = 1;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk("to_latency", n, 19);
    chk("to_err", rsp_err, 1'b1);
    chk("to_rdata", rsp_rdata, 8'h00);
    step();
    lat_force = 15;
    repeat (2) step();
    send(1'b0, 4'h5, 100'h0);
    n = 1;
    while (!rsp_valid && n < 40) begin
      step();
      n++;
    end
    chk("to_edge_latency", n, 19);
    chk("to_edge_err", rsp_err, 1'b0);
    chk("to_edge_rdata", rsp_rdata, 8'hFF);
    step();
    lat_force = -1;
`endif

    // Back-pressure: 1 command in flight plus 4 in the FIFO, then a held response
    rsp_ready = 1'b0;
    n0 = n_rsp;
    bp_acc = 0;
    for (int i = 0; i < 8; i++) begin
      cmd_valid = 1'b1;
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 4'($urandom_range(0, 15));
      cmd_wdata = rnd_wdata();
      if (cmd_ready) bp_acc++;
      step();
    end
    cmd_valid = 1'b0;
    chk("bp_accepts", bp_acc, 5);
    chk("bp_cmd_ready", cmd_ready, 1'b0);
    repeat (10) step();
    chk("bp_held_none", n_rsp - n0, 0);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    repeat (3) step();
    chk("bp_one_consumed", n_rsp - n0, 1);
    rsp_ready = 1'b1;
    wait_idle("bp_drain_busy");
    chk("bp_all_rsp", n_rsp - n0, 5);

    // Asynchronous reset during WAIT with two commands queued
    lat_force = 1000;
    repeat (2) step();
    send(1'b0, 4'h7, 100'h0);
    send(1'b1, 4'h8, 100'h1);
    send(1'b1, 4'h9, 100'h2);
    repeat (2) step();
    chk("ar_pre_busy", busy, 1'b1);
    n0 = n_rsp;
    #1 rst_n = 1'b0;
    #1;
    chk("ar_ren", mem_read_en, 1'b0);
    chk("ar_wen", mem_write_en, 1'b0);
    chk("ar_rsp_valid", rsp_valid, 1'b0);
    chk("ar_cmd_ready", cmd_ready, 1'b1);
    chk("ar_busy", busy, 1'b0);
    chk("ar_addr", mem_addr, 4'h0);
    repeat (2) step();
    rst_n = 1'b1;
    lat_force = -1;
    repeat (10) step();
    chk("ar_no_rsp", n_rsp - n0, 0);
    chk("ar_idle", busy, 1'b0);

    // Random traffic
    lat_max = 3;
    for (int i = 0; i < 1500; i++) begin
      cmd_valid = ($urandom_range(0, 2) != 0);
      cmd_write = 1'($urandom_range(0, 1));
      cmd_addr  = 4'($urandom_range(0, 15));
      cmd_wdata = rnd_wdata();
      rsp_ready = ($urandom_range(0, 3) != 0);
      step();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("rand_drain_busy");
    repeat (2) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
